// File: rtl/axis_input_packer.sv
// Packs narrow AXIS words (word 0 in the LSBs) into one wide AXIS beat; early TLAST zero-fills the rest.
// Latency: beat valid the cycle after the completing word handshake; one input word per cycle sustained.
// Backpressure: a one-beat output register plus the accumulator; S_AXIS_TREADY drops only while a completed beat waits.
module axis_input_packer #(
    parameter int arraySize = 2,
    parameter int inputBits = 8,
    parameter int inWidth   = 32,
    parameter int outWidth  = arraySize*inputBits*5+48,
    parameter int WORDS     = (outWidth+inWidth-1)/inWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [inWidth-1:0]    S_AXIS_TDATA,
    input  logic [inWidth/8-1:0]  S_AXIS_TKEEP,
    input  logic                  S_AXIS_TLAST,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    output logic [outWidth-1:0]   M_AXIS_TDATA,
    output logic [outWidth/8-1:0] M_AXIS_TKEEP,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY
);

    localparam int ACC_W = WORDS*inWidth;
    localparam int IN_B  = inWidth/8;
    localparam int ACC_B = ACC_W/8;
    localparam int OUT_B = outWidth/8;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {ST_ACCUM, ST_WAIT} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_B-1:0]    acc_keep_q, acc_keep_d;
    logic                acc_last_q, acc_last_d;
    logic                out_vld_q, out_vld_d;
    logic [outWidth-1:0] out_dat_q, out_dat_d;
    logic [OUT_B-1:0]    out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;
    logic                rdy_q, rdy_d;

    logic                s_rdy, s_hs, m_hs, beat_done;
    logic [ACC_W-1:0]    beat_dat;
    logic [ACC_B-1:0]    beat_keep;
    int                  word_idx;

    // Input keep is assumed all-ones; unreceived words are tracked by the counter instead.
    logic unused_keep;
    assign unused_keep = ^S_AXIS_TKEEP;

    always_comb begin
        s_rdy     = rdy_q && (state_q == ST_ACCUM);
        s_hs      = S_AXIS_TVALID && s_rdy;
        m_hs      = out_vld_q && M_AXIS_TREADY;
        word_idx  = int'(cnt_q);
        beat_dat  = acc_q;
        beat_keep = acc_keep_q;
        beat_dat[word_idx*inWidth +: inWidth] = S_AXIS_TDATA;
        beat_keep[word_idx*IN_B +: IN_B]      = '1;
        beat_done = s_hs && (S_AXIS_TLAST || (cnt_q == CW'(WORDS-1)));

        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        acc_last_d = acc_last_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        rdy_d      = 1'b1;

        if (m_hs) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            ST_ACCUM: begin
                if (beat_done) begin
                    cnt_d = '0;
                    if (!out_vld_q || m_hs) begin
                        // Output slot free (or freeing now): reload with no bubble.
                        out_vld_d  = 1'b1;
                        out_dat_d  = beat_dat[outWidth-1:0];
                        out_keep_d = beat_keep[OUT_B-1:0];
                        out_last_d = S_AXIS_TLAST;
                        acc_d      = '0;
                        acc_keep_d = '0;
                        acc_last_d = 1'b0;
                    end else begin
                        state_d    = ST_WAIT;
                        acc_d      = beat_dat;
                        acc_keep_d = beat_keep;
                        acc_last_d = S_AXIS_TLAST;
                    end
                end else if (s_hs) begin
                    cnt_d      = cnt_q + 1'b1;
                    acc_d      = beat_dat;
                    acc_keep_d = beat_keep;
                end
            end
            ST_WAIT: begin
                if (m_hs) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = acc_q[outWidth-1:0];
                    out_keep_d = acc_keep_q[OUT_B-1:0];
                    out_last_d = acc_last_q;
                    acc_d      = '0;
                    acc_keep_d = '0;
                    acc_last_d = 1'b0;
                    state_d    = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_ACCUM;
            cnt_q      <= '0;
            acc_q      <= '0;
            acc_keep_q <= '0;
            acc_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
            acc_last_q <= acc_last_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
            rdy_q      <= rdy_d;
        end
    end

    assign S_AXIS_TREADY = s_rdy;
    assign M_AXIS_TDATA  = out_dat_q;
    assign M_AXIS_TKEEP  = out_keep_q;
    assign M_AXIS_TLAST  = out_last_q;
    assign M_AXIS_TVALID = out_vld_q;

endmodule

// File: tb/tb_axis_input_packer.sv
// Randomized and directed bench for axis_input_packer at default parameters (32 -> 128 bits, 4 words/beat).
module tb_axis_input_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  S_AXIS_TDATA;
    logic [3:0]   S_AXIS_TKEEP;
    logic         S_AXIS_TLAST;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TREADY;
    logic [127:0] M_AXIS_TDATA;
    logic [15:0]  M_AXIS_TKEEP;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TREADY;

    axis_input_packer dut (
        .clk(clk), .rst(rst),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int beats_rx = 0;
    beat_t exp_q[$];
    int    beat_cyc[$];

    // Reference packer state: words received for the beat in progress.
    logic [127:0] part_dat = '0;
    int           part_n   = 0;

    logic         stall_prev = 1'b0;
    logic [127:0] held_d;
    logic [15:0]  held_k;
    logic         held_l;
    logic         rnd_done;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: builds expected beats from observed input handshakes and checks every output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            part_dat   = '0;
            part_n     = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", M_AXIS_TVALID, 1'b1);
                chk("hold_data", M_AXIS_TDATA, held_d);
                chk("hold_keep", M_AXIS_TKEEP, held_k);
                chk("hold_last", M_AXIS_TLAST, held_l);
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                beats_rx++;
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("sb_data", M_AXIS_TDATA, e.d);
                    chk("sb_keep", M_AXIS_TKEEP, e.k);
                    chk("sb_last", M_AXIS_TLAST, e.l);
                end
            end
            stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
            held_d = M_AXIS_TDATA;
            held_k = M_AXIS_TKEEP;
            held_l = M_AXIS_TLAST;
            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                part_dat = part_dat | ({96'd0, S_AXIS_TDATA} << (32*part_n));
                part_n++;
                if (part_n == 4 || S_AXIS_TLAST) begin
                    beat_t b;
                    b.d = part_dat;
                    b.k = 16'((32'h1 << (4*part_n)) - 32'h1);
                    b.l = S_AXIS_TLAST;
                    exp_q.push_back(b);
                    part_dat = '0;
                    part_n   = 0;
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l, output int stalls);
        stalls = 0;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (S_AXIS_TREADY) begin
                @(posedge clk);
                #1;
                S_AXIS_TVALID = 1'b0;
                return;
            end
            stalls++;
        end
        tests++;
        fails++;
        $display("FAIL send_word: no input handshake, got TREADY=%b, expected 1", S_AXIS_TREADY);
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int st_sum;
        int snap;
        logic [7:0] b;
        rst = 1'b0;
        S_AXIS_TDATA = '0; S_AXIS_TKEEP = 4'hF; S_AXIS_TLAST = 1'b0; S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = 1'b1;
        rnd_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
        chk("rst_tdata", M_AXIS_TDATA, '0);
        chk("rst_tkeep", M_AXIS_TKEEP, '0);
        chk("rst_tlast", M_AXIS_TLAST, 1'b0);
        chk("rst_s_tready", S_AXIS_TREADY, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: full beat, latency one cycle after the last word handshake
        send_word(32'h03020100, 1'b0, st);
        send_word(32'h07060504, 1'b0, st);
        send_word(32'h0B0A0908, 1'b0, st);
        send_word(32'h0F0E0D0C, 1'b1, st);
        chk("t1_tvalid", M_AXIS_TVALID, 1'b1);
        chk("t1_tdata", M_AXIS_TDATA, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("t1_tkeep", M_AXIS_TKEEP, 16'hFFFF);
        chk("t1_tlast", M_AXIS_TLAST, 1'b1);
        idle(3);

        // 2: eight back-to-back words, no input stall
        beat_cyc.delete();
        st_sum = 0;
        for (int i = 0; i < 8; i++) begin
            send_word(32'h11110000 + 32'(i), i == 7, st);
            st_sum += st;
        end
        idle(3);
        chk("t2_stalls", 32'(st_sum), 32'd0);
        chk("t2_beats", 32'(beat_cyc.size()), 32'd2);
        if (beat_cyc.size() == 2) chk("t2_gap", 32'(beat_cyc[1] - beat_cyc[0]), 32'd4);

        // 3: short packet zero-fills, next packet restarts at word 0
        send_word(32'hAAAAAAAA, 1'b0, st);
        send_word(32'hBBBBBBBB, 1'b1, st);
        chk("t3_tdata", M_AXIS_TDATA, 128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
        chk("t3_tkeep", M_AXIS_TKEEP, 16'h00FF);
        chk("t3_tlast", M_AXIS_TLAST, 1'b1);
        idle(2);
        for (int i = 0; i < 4; i++) send_word(32'h10 + 32'(i), i == 3, st);
        chk("t3_next_tdata", M_AXIS_TDATA, 128'h00000013_00000012_00000011_00000010);
        chk("t3_next_tkeep", M_AXIS_TKEEP, 16'hFFFF);
        idle(3);

        // 4: backpressure into WAIT, then same-edge drain and reload
        M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = 8'h40 + 8'(i);
            send_word({4{b}}, i == 7, st);
        end
        chk("t4_s_tready_wait", S_AXIS_TREADY, 1'b0);
        chk("t4_tvalid", M_AXIS_TVALID, 1'b1);
        chk("t4_beat1", M_AXIS_TDATA, 128'h43434343_42424242_41414141_40404040);
        chk("t4_beat1_last", M_AXIS_TLAST, 1'b0);
        idle(3);
        chk("t4_still_wait", S_AXIS_TREADY, 1'b0);
        M_AXIS_TREADY = 1'b1;
        @(posedge clk); #1;
        chk("t4_beat2_vld", M_AXIS_TVALID, 1'b1);
        chk("t4_beat2", M_AXIS_TDATA, 128'h47474747_46464646_45454545_44444444);
        chk("t4_beat2_last", M_AXIS_TLAST, 1'b1);
        chk("t4_s_tready_back", S_AXIS_TREADY, 1'b1);
        idle(3);

        // 5: async reset with a pending beat and a partial accumulator
        M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 6; i++) send_word(32'hDEAD0000 + 32'(i), 1'b0, st);
        chk("t5_pending", M_AXIS_TVALID, 1'b1);
        rst = 1'b0;
        #1;
        chk("t5_rst_tvalid", M_AXIS_TVALID, 1'b0);
        chk("t5_rst_tdata", M_AXIS_TDATA, '0);
        chk("t5_rst_tkeep", M_AXIS_TKEEP, '0);
        chk("t5_rst_s_tready", S_AXIS_TREADY, 1'b0);
        idle(3);
        rst = 1'b1;
        M_AXIS_TREADY = 1'b1;
        snap = beats_rx;
        for (int i = 0; i < 4; i++) send_word(32'h55550000 + 32'(i), i == 3, st);
        chk("t5_fresh", M_AXIS_TDATA, 128'h55550003_55550002_55550001_55550000);
        idle(4);
        chk("t5_beats_after_rst", 32'(beats_rx - snap), 32'd1);

        // 6: random valid/ready traffic against the scoreboard
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    idle($urandom_range(0, 2));
                    send_word($urandom, (i == 999) || ($urandom_range(0, 4) == 0), st);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
                end
            end
        join
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !M_AXIS_TVALID) break;
        end
        chk("t6_drained", 32'(exp_q.size()), 32'd0);
        chk("t6_partial", 32'(part_n), 32'd0);
        chk("t6_tvalid_idle", M_AXIS_TVALID, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
